apb_intercon_rr: RTL

Parametrised N-master to M-slave APB interconnect with round-robin arbitration, registered decode and decode-error completion. Successor to the single-grant cluster-to-main-memory interconnect: it sits between the cluster masters (S side) and the main-bus peripherals such as DMEM and the peripheral section (M side). It guarantees bounded-latency fairness across masters.

---
 rtl/apb_intercon_rr_pkg.sv | 30 +++
 rtl/apb_intercon_rr_arbiter.sv | 78 +++++++
 rtl/apb_intercon_rr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_intercon_rr_pkg.sv
// apb_intercon_rr_pkg
// Shared definitions for the round-robin APB interconnect:
//   - FSM state encodings (IDLE / SETUP / ACCESS / DONE)
//   - read data returned to a master when an access times out
//   - default slave-index field position and the main-bus slave map
//   - clog2_min1: index width helper that never returns 0
package apb_intercon_rr_pkg;

   typedef logic [1:0] ic_state_t;

   localparam ic_state_t ST_IDLE   = 2'd0;
   localparam ic_state_t ST_SETUP  = 2'd1;
   localparam ic_state_t ST_ACCESS = 2'd2;
   localparam ic_state_t ST_DONE   = 2'd3;

   // Data returned on an access-phase timeout, sliced to DATA_WIDTH by the user
   localparam logic [63:0] IC_TIMEOUT_RDATA = {64{1'b1}};

   // Default slave-index field within PADDR and the main-bus slave map
   localparam int IC_ADDR_MSB_DEF   = 12;
   localparam int IC_ADDR_LSB_DEF   = 12;
   localparam int IC_DMEM_IDX       = 0;
   localparam int IC_PERIPH_IDX     = 1;

   // Width needed to index n items; a single item still gets one bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_intercon_rr_arbiter.sv
// apb_rr_arbiter
// Round-robin arbiter for the APB interconnect. The pointer holds the last
// granted index; the search starts just after it and wraps, so the reset
// value PORTS-1 makes port 0 the first winner.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req          per-port request vector
//   take         the grant is consumed this cycle (pointer advances if any req)
//   grant        one-hot grant (combinational)
//   grant_idx    encoded grant index (combinational)
//   any_req      at least one request present
module apb_rr_arbiter
   import apb_intercon_rr_pkg::*;
#(
   parameter  int PORTS = 4,
   localparam int IDX_W = clog2_min1(PORTS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PORTS-1:0] req,
   input  logic             take,
   output logic [PORTS-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;
   int               best_s;
   int               dist_s;

   // Pick the requester with the smallest circular distance past the pointer
   always_comb begin
      idx_s   = '0;
      found_s = 1'b0;
      best_s  = PORTS;
      dist_s  = 0;
      for (int i = 0; i < PORTS; i++) begin
         dist_s = i - int'(ptr_r) - 1;
         if (dist_s < 0) begin
            dist_s = dist_s + PORTS;
         end else begin
            dist_s = dist_s;
         end
         if (req[i] && (dist_s < best_s)) begin
            best_s  = dist_s;
            idx_s   = IDX_W'(i);
            found_s = 1'b1;
         end else begin
            best_s  = best_s;
         end
      end
   end

   // Expand the winning index to a one-hot grant
   always_comb begin
      grant = '0;
      for (int i = 0; i < PORTS; i++) begin
         grant[i] = found_s && (idx_s == IDX_W'(i));
      end
   end

   assign grant_idx = idx_s;
   assign any_req   = |req;

   // Pointer remembers the last winner
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= IDX_W'(PORTS - 1);
      end else if (take && any_req) begin
         ptr_r <= idx_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr
// N-master to M-slave APB interconnect with round-robin arbitration,
// registered address decode and decode-error completion. One transfer is in
// flight at a time; the latched copies of the granted request drive M_*.
// Optional feature macro: APB_IC_TIMEOUT_EN adds an access-phase watchdog
// that completes a stuck access with all-ones read data after TIMEOUT_CYCLES.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   S_PADDR/S_PWRITE/S_PSELx/
//   S_PENABLE/S_PWDATA              per-master APB request inputs
//   S_PRDATA                        per-master registered read data
//   S_PREADY                        per-master one-cycle completion pulse
//   M_PADDR/M_PWRITE/M_PWDATA       shared downstream request (latched)
//   M_PSELx                         one-hot slave select
//   M_PENABLE                       downstream access phase
//   M_PRDATA/M_PREADY               per-slave response inputs
module apb_intercon_rr
   import apb_intercon_rr_pkg::*;
#(
   parameter int BUS_WIDTH      = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int MASTER_PORTS   = 4,
   parameter int SLAVE_PORTS    = 2,
   parameter int ADDR_MSB       = IC_ADDR_MSB_DEF,
   parameter int ADDR_LSB       = IC_ADDR_LSB_DEF,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
   input  logic [MASTER_PORTS-1:0]            S_PWRITE,
   input  logic [MASTER_PORTS-1:0]            S_PSELx,
   input  logic [MASTER_PORTS-1:0]            S_PENABLE,
   input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
   output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
   output logic [MASTER_PORTS-1:0]            S_PREADY,
   output logic [BUS_WIDTH-1:0]               M_PADDR,
   output logic                               M_PWRITE,
   output logic [SLAVE_PORTS-1:0]             M_PSELx,
   output logic                               M_PENABLE,
   output logic [DATA_WIDTH-1:0]              M_PWDATA,
   input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
   input  logic [SLAVE_PORTS-1:0]             M_PREADY
);

   localparam int MIDX_W = clog2_min1(MASTER_PORTS);
   localparam int SIDX_W = clog2_min1(SLAVE_PORTS);
   localparam int DEC_W  = ADDR_MSB - ADDR_LSB + 1;

   ic_state_t                  state_r;
   ic_state_t                  state_nx_s;
   logic [MIDX_W-1:0]          gnt_idx_r;
   logic [SIDX_W-1:0]          slv_idx_r;

   logic [MASTER_PORTS-1:0]    req_s;
   logic [MASTER_PORTS-1:0]    arb_grant_s;
   logic [MIDX_W-1:0]          arb_idx_s;
   logic                       any_req_s;

   logic [BUS_WIDTH-1:0]       req_addr_s;
   logic                       req_write_s;
   logic [DATA_WIDTH-1:0]      req_wdata_s;
   logic [DEC_W-1:0]           dec_field_s;
   logic                       dec_err_s;
   logic [SLAVE_PORTS-1:0]     dec_onehot_s;

   logic [DATA_WIDTH-1:0]      slv_rdata_s;
   logic                       slv_ready_s;
   logic [MASTER_PORTS-1:0]    gnt_onehot_s;
   logic                       to_hit_s;

   logic                       load_s;
   logic [SLAVE_PORTS-1:0]     psel_nx_s;
   logic                       pen_nx_s;
   logic [MASTER_PORTS-1:0]    pready_nx_s;
   logic                       rd_upd_s;
   logic [MIDX_W-1:0]          rd_idx_s;
   logic [DATA_WIDTH-1:0]      rd_data_s;

   // Only the access phase counts as a request; setup-only cycles are ignored
   assign req_s = S_PSELx & S_PENABLE;

   apb_rr_arbiter #(
      .PORTS     (MASTER_PORTS)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_s),
      .take      (state_r == ST_IDLE),
      .grant     (arb_grant_s),
      .grant_idx (arb_idx_s),
      .any_req   (any_req_s)
   );

   // Select the winning master's request fields
   always_comb begin
      req_addr_s  = '0;
      req_write_s = 1'b0;
      req_wdata_s = '0;
      for (int i = 0; i < MASTER_PORTS; i++) begin
         if (arb_idx_s == MIDX_W'(i)) begin
            req_addr_s  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
            req_write_s = S_PWRITE[i];
            req_wdata_s = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            req_addr_s  = req_addr_s;
         end
      end
   end

   // Decode the slave index; an out-of-range index selects nothing
   always_comb begin
      dec_field_s  = req_addr_s[ADDR_MSB:ADDR_LSB];
      dec_err_s    = (32'(dec_field_s) >= 32'(SLAVE_PORTS));
      dec_onehot_s = '0;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         dec_onehot_s[s] = (32'(dec_field_s) == 32'(s));
      end
   end

   // Route the addressed slave's response and expand the latched grant
   always_comb begin
      slv_rdata_s  = '0;
      slv_ready_s  = 1'b0;
      gnt_onehot_s = '0;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         if (slv_idx_r == SIDX_W'(s)) begin
            slv_rdata_s = M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
            slv_ready_s = M_PREADY[s];
         end else begin
            slv_rdata_s = slv_rdata_s;
         end
      end
      for (int m = 0; m < MASTER_PORTS; m++) begin
         gnt_onehot_s[m] = (gnt_idx_r == MIDX_W'(m));
      end
   end

`ifdef APB_IC_TIMEOUT_EN
   localparam int TO_W = (clog2_min1(TIMEOUT_CYCLES + 1) > 8) ?
                         clog2_min1(TIMEOUT_CYCLES + 1) : 8;
   logic [TO_W-1:0] to_cnt_r;

   assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts access-phase cycles; cleared whenever the FSM is elsewhere
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_r <= '0;
      end else if (state_r == ST_ACCESS) begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
         to_cnt_r <= '0;
      end
   end
`else
   assign to_hit_s = 1'b0;
`endif

   // Transfer FSM next-state and registered-output next values
   always_comb begin
      state_nx_s  = state_r;
      load_s      = 1'b0;
      psel_nx_s   = M_PSELx;
      pen_nx_s    = 1'b0;
      pready_nx_s = '0;
      rd_upd_s    = 1'b0;
      rd_idx_s    = gnt_idx_r;
      rd_data_s   = '0;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               load_s   = 1'b1;
               rd_idx_s = arb_idx_s;
               if (dec_err_s) begin
                  // No slave owns this address: complete at once with zero data
                  state_nx_s  = ST_DONE;
                  psel_nx_s   = '0;
                  pready_nx_s = arb_grant_s;
                  rd_upd_s    = 1'b1;
                  rd_data_s   = '0;
               end else begin
                  state_nx_s  = ST_SETUP;
                  psel_nx_s   = dec_onehot_s;
               end
            end else begin
               psel_nx_s = '0;
            end
         end
         ST_SETUP: begin
            state_nx_s = ST_ACCESS;
            pen_nx_s   = 1'b1;
         end
         ST_ACCESS: begin
            if (slv_ready_s) begin
               state_nx_s  = ST_DONE;
               psel_nx_s   = '0;
               pready_nx_s = gnt_onehot_s;
               rd_upd_s    = !M_PWRITE;
               rd_data_s   = slv_rdata_s;
            end else if (to_hit_s) begin
               state_nx_s  = ST_DONE;
               psel_nx_s   = '0;
               pready_nx_s = gnt_onehot_s;
               rd_upd_s    = 1'b1;
               rd_data_s   = IC_TIMEOUT_RDATA[DATA_WIDTH-1:0];
            end else begin
               pen_nx_s    = 1'b1;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
            psel_nx_s  = '0;
         end
         default: begin
            state_nx_s = ST_IDLE;
            psel_nx_s  = '0;
         end
      endcase
   end

   // FSM state, latched request copy and downstream/completion outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         gnt_idx_r <= '0;
         slv_idx_r <= '0;
         M_PADDR   <= '0;
         M_PWRITE  <= 1'b0;
         M_PWDATA  <= '0;
         M_PSELx   <= '0;
         M_PENABLE <= 1'b0;
         S_PREADY  <= '0;
      end else begin
         state_r   <= state_nx_s;
         M_PSELx   <= psel_nx_s;
         M_PENABLE <= pen_nx_s;
         S_PREADY  <= pready_nx_s;
         if (load_s) begin
            gnt_idx_r <= arb_idx_s;
            slv_idx_r <= SIDX_W'(dec_field_s);
            M_PADDR   <= req_addr_s;
            M_PWRITE  <= req_write_s;
            M_PWDATA  <= req_wdata_s;
         end else begin
            gnt_idx_r <= gnt_idx_r;
         end
      end
   end

   // Per-master read data; only the completing master's slice changes
   always_ff @(posedge clk) begin
      if (reset) begin
         S_PRDATA <= '0;
      end else begin
         for (int m = 0; m < MASTER_PORTS; m++) begin
            if (rd_upd_s && (rd_idx_s == MIDX_W'(m))) begin
               S_PRDATA[m*DATA_WIDTH +: DATA_WIDTH] <= rd_data_s;
            end
         end
      end
   end

endmodule
